l2_home_responder: RTL and testbench



---
 rtl/l2_home_responder_pkg.sv | 27 ++
 rtl/l2_home_store.sv | 29 ++
 rtl/l2_home_responder.sv | 114 +++++++++++
 tb/tb_l2_home_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_home_responder_pkg.sv
// l2_home_responder_pkg: Spandex field types, opcodes, home FSM state and opcode helpers
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif
package l2_home_responder_pkg;
  localparam int WORDS = `WORDS_PER_LINE;
  localparam int WORD_BITS = 32;
  localparam int ADDR_BITS = 28;
  localparam int INVACK_BITS = 4;
  typedef logic [2:0] mix_msg_t;
  typedef logic [2:0] coh_msg_t;
  typedef logic [1:0] hprot_t;
  typedef logic [ADDR_BITS-1:0] line_addr_t;
  typedef logic [WORDS*WORD_BITS-1:0] line_t;
  typedef logic [WORDS-1:0] word_mask_t;
  typedef logic [INVACK_BITS-1:0] invack_cnt_t;
  localparam mix_msg_t REQ_S = 3'd0, REQ_O = 3'd1, REQ_V = 3'd2, REQ_WT = 3'd3, REQ_ODATA = 3'd4, REQ_WB = 3'd5;
  localparam coh_msg_t RSP_S = 3'd1, RSP_O = 3'd2, RSP_V = 3'd3, RSP_WT = 3'd4, RSP_ODATA = 3'd5, RSP_WB_ACK = 3'd6;
  typedef enum logic [2:0] {INIT, IDLE, READ, WAIT, RESP} home_state_t;
  function automatic logic is_supported(input mix_msg_t m);
    return m inside {REQ_S, REQ_O, REQ_V, REQ_WT, REQ_ODATA, REQ_WB};
  endfunction
  function automatic coh_msg_t rsp_of(input mix_msg_t m);
    return m == REQ_S ? RSP_S : m == REQ_O ? RSP_O : m == REQ_V ? RSP_V :
           m == REQ_WT ? RSP_WT : m == REQ_ODATA ? RSP_ODATA : RSP_WB_ACK;
  endfunction
endpackage

// File: rtl/l2_home_store.sv
// l2_home_store: direct-indexed line + owner RAM, one sync read port, one word-masked write port
module l2_home_store
  import l2_home_responder_pkg::*;
#(
  parameter int N_LINES = 64,
  localparam int IW = $clog2(N_LINES)
) (
  input  logic          clk,
  input  logic [IW-1:0] raddr_i,
  output line_t         rline_o,
  output word_mask_t    rown_o,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  word_mask_t    wmask_i,
  input  line_t         wline_i,
  input  word_mask_t    wown_i
);
  line_t line_mem [N_LINES];
  word_mask_t own_mem [N_LINES];
  always_ff @(posedge clk) begin
    rline_o <= line_mem[raddr_i];
    rown_o <= own_mem[raddr_i];
    if (we_i) begin
      own_mem[waddr_i] <= wown_i;
      for (int w = 0; w < WORDS; w++)
        if (wmask_i[w]) line_mem[waddr_i][w*WORD_BITS +: WORD_BITS] <= wline_i[w*WORD_BITS +: WORD_BITS];
    end
  end
endmodule

// File: rtl/l2_home_responder.sv
// l2_home_responder: Spandex L2 home agent over a line/owner store; L2_HOME_RSP_LATENCY_EN adds RSP_LAT wait cycles
module l2_home_responder
  import l2_home_responder_pkg::*;
#(
  parameter int N_LINES = 64,
  parameter int RSP_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l2_req_out_valid,
  output logic        l2_req_out_ready,
  input  mix_msg_t    l2_req_out_coh_msg,
  input  hprot_t      l2_req_out_hprot,
  input  line_addr_t  l2_req_out_addr,
  input  line_t       l2_req_out_line,
  input  word_mask_t  l2_req_out_word_mask,
  output logic        l2_rsp_in_valid,
  input  logic        l2_rsp_in_ready,
  output coh_msg_t    l2_rsp_in_coh_msg,
  output line_addr_t  l2_rsp_in_addr,
  output line_t       l2_rsp_in_line,
  output word_mask_t  l2_rsp_in_word_mask,
  output invack_cnt_t l2_rsp_in_invack_cnt,
  output logic        err_pulse
);
  localparam int IW = $clog2(N_LINES);
  home_state_t state_q, state_d;
  logic [IW-1:0] cnt_q, waddr;
  mix_msg_t msg_q;
  line_addr_t addr_q;
  line_t line_q, rsp_line_q, rd_line, wline;
  word_mask_t mask_q, rd_own, wmask, wown;
  coh_msg_t rsp_msg_q;
  logic sup, keeps_line, merges, we, unused_ok;
  assign unused_ok = ^{l2_req_out_hprot, RSP_LAT};
`ifdef L2_HOME_RSP_LATENCY_EN
  localparam int LW = $clog2(RSP_LAT + 2);
  localparam logic [LW-1:0] LAT_LOAD = LW'(RSP_LAT == 0 ? 0 : RSP_LAT - 1);
  logic [LW-1:0] lat_q;
  always_ff @(posedge clk)
    lat_q <= rst ? '0 : state_q == READ ? LAT_LOAD : (state_q == WAIT && lat_q != '0) ? lat_q - 1'b1 : lat_q;
`endif
  always_ff @(posedge clk) state_q <= rst ? INIT : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: state_d = cnt_q == IW'(N_LINES - 1) ? IDLE : INIT;
      IDLE: state_d = l2_req_out_valid ? READ : IDLE;
`ifdef L2_HOME_RSP_LATENCY_EN
      READ: state_d = sup ? WAIT : IDLE;
      WAIT: state_d = lat_q == '0 ? RESP : WAIT;
`else
      READ: state_d = sup ? RESP : IDLE;
`endif
      RESP: state_d = l2_rsp_in_ready ? IDLE : RESP;
      default: state_d = INIT;
    endcase
  end
  always_comb begin
    l2_req_out_ready = state_q == IDLE;
    l2_rsp_in_valid = state_q == RESP;
    err_pulse = state_q == READ && !sup;
  end
  always_comb begin
    sup = is_supported(msg_q);
    keeps_line = msg_q inside {REQ_V, REQ_S, REQ_ODATA};
    merges = msg_q inside {REQ_WT, REQ_WB};
    we = state_q == INIT || (state_q == READ && sup);
    waddr = state_q == INIT ? cnt_q : addr_q[IW-1:0];
    wmask = state_q == INIT ? '1 : merges ? mask_q : '0;
    wline = state_q == INIT ? '0 : line_q;
    wown = state_q == INIT ? '0 : (msg_q inside {REQ_O, REQ_ODATA}) ? (rd_own | mask_q) :
           msg_q == REQ_WB ? (rd_own & ~mask_q) : rd_own;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      msg_q <= '0;
      addr_q <= '0;
      line_q <= '0;
      mask_q <= '0;
      rsp_msg_q <= '0;
      rsp_line_q <= '0;
    end else begin
      if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE && l2_req_out_valid) begin
        msg_q <= l2_req_out_coh_msg;
        addr_q <= l2_req_out_addr;
        line_q <= l2_req_out_line;
        mask_q <= l2_req_out_word_mask;
      end
      if (state_q == READ) begin
        rsp_msg_q <= rsp_of(msg_q);
        rsp_line_q <= keeps_line ? rd_line : '0;
      end
    end
  end
  l2_home_store #(.N_LINES(N_LINES)) u_store (
    .clk    (clk),
    .raddr_i(l2_req_out_addr[IW-1:0]),
    .rline_o(rd_line),
    .rown_o (rd_own),
    .we_i   (we),
    .waddr_i(waddr),
    .wmask_i(wmask),
    .wline_i(wline),
    .wown_i (wown)
  );
  assign l2_rsp_in_coh_msg = rsp_msg_q;
  assign l2_rsp_in_addr = addr_q;
  assign l2_rsp_in_line = rsp_line_q;
  assign l2_rsp_in_word_mask = mask_q;
  assign l2_rsp_in_invack_cnt = '0;
endmodule

// File: tb/tb_l2_home_responder.sv
// tb_l2_home_responder: randomized self-checking bench against a word-level store model
module tb_l2_home_responder;
  import l2_home_responder_pkg::*;
  localparam int N = 64;
  localparam int LAT_P = 4;
`ifdef L2_HOME_RSP_LATENCY_EN
  localparam int EXP_LAT = LAT_P + 2;
`else
  localparam int EXP_LAT = 2;
`endif
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, err_pulse;
  mix_msg_t req_msg = '0;
  hprot_t req_hprot = '0;
  line_addr_t req_addr = '0, rsp_addr;
  line_t req_line = '0, rsp_line;
  word_mask_t req_mask = '0, rsp_mask;
  coh_msg_t rsp_msg;
  invack_cnt_t rsp_inv;
  int checks = 0, failures = 0;
  line_t m_line [N];
  word_mask_t m_own [N];
  always #5 clk = ~clk;
  l2_home_responder #(.N_LINES(N), .RSP_LAT(LAT_P)) dut (
    .clk(clk), .rst(rst),
    .l2_req_out_valid(req_valid), .l2_req_out_ready(req_ready),
    .l2_req_out_coh_msg(req_msg), .l2_req_out_hprot(req_hprot),
    .l2_req_out_addr(req_addr), .l2_req_out_line(req_line),
    .l2_req_out_word_mask(req_mask),
    .l2_rsp_in_valid(rsp_valid), .l2_rsp_in_ready(rsp_ready),
    .l2_rsp_in_coh_msg(rsp_msg), .l2_rsp_in_addr(rsp_addr),
    .l2_rsp_in_line(rsp_line), .l2_rsp_in_word_mask(rsp_mask),
    .l2_rsp_in_invack_cnt(rsp_inv), .err_pulse(err_pulse)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_line[i] = '0;
      m_own[i] = '0;
    end
  endtask
  function automatic logic model(input mix_msg_t m, input line_addr_t a, input line_t l, input word_mask_t k,
                                 output coh_msg_t rm, output line_t rl);
    int i = int'(a[$clog2(N)-1:0]);
    rm = '0;
    rl = '0;
    model = 1'b1;
    case (m)
      REQ_V: begin rm = RSP_V; rl = m_line[i]; end
      REQ_S: begin rm = RSP_S; rl = m_line[i]; end
      REQ_ODATA: begin rm = RSP_ODATA; rl = m_line[i]; m_own[i] |= k; end
      REQ_O: begin rm = RSP_O; m_own[i] |= k; end
      REQ_WT, REQ_WB: begin
        rm = m == REQ_WT ? RSP_WT : RSP_WB_ACK;
        for (int w = 0; w < WORDS; w++)
          if (k[w]) m_line[i][w*WORD_BITS +: WORD_BITS] = l[w*WORD_BITS +: WORD_BITS];
        if (m == REQ_WB) m_own[i] &= ~k;
      end
      default: model = 1'b0;
    endcase
  endfunction
  task automatic count_init();
    int n = 0;
    while (!req_ready && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL init_len got=%0d want=64", n);
    end
    model_clear();
  endtask
  task automatic do_req(input mix_msg_t m, input line_addr_t a, input line_t l, input word_mask_t k, input int hold);
    coh_msg_t em;
    line_t el;
    logic has;
    int n = 0;
    int idx = int'(a[$clog2(N)-1:0]);
    has = model(m, a, l, k, em, el);
    while (!req_ready && n < 200) begin step(); n++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL req_ready_timeout got=0 want=1");
      return;
    end
    req_valid = 1; req_msg = m; req_addr = a; req_line = l; req_mask = k;
    req_hprot = hprot_t'($urandom);
    step();
    req_valid = 0;
    if (!has) begin
      checks++;
      if (err_pulse !== 1'b1 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL err_pulse got err=%b valid=%b want err=1 valid=0", err_pulse, rsp_valid);
      end
      step();
      checks++;
      if (err_pulse !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL err_recover got err=%b valid=%b ready=%b want 0 0 1", err_pulse, rsp_valid, req_ready);
      end
      return;
    end
    n = 1;
    while (!rsp_valid && n < 50) begin step(); n++; end
    checks++;
    if (!rsp_valid || n !== EXP_LAT) begin
      failures++;
      $display("FAIL latency got=%0d valid=%b want=%0d", n, rsp_valid, EXP_LAT);
    end
    for (int c = 0; c <= hold; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_msg !== em || rsp_addr !== a || rsp_line !== el ||
          rsp_mask !== k || rsp_inv !== '0) begin
        failures++;
        $display("FAIL rsp_fields cyc=%0d got v=%b rdy=%b msg=%0d addr=%h mask=%b inv=%0d line=%h want v=1 rdy=0 msg=%0d addr=%h mask=%b inv=0 line=%h",
                 c, rsp_valid, req_ready, rsp_msg, rsp_addr, rsp_mask, rsp_inv, rsp_line, em, a, k, el);
      end
      if (c < hold) step();
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
    checks++;
    if (dut.u_store.own_mem[idx] !== m_own[idx]) begin
      failures++;
      $display("FAIL owner idx=%0d got=%b want=%b", idx, dut.u_store.own_mem[idx], m_own[idx]);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || err_pulse !== 1'b0 || rsp_msg !== '0 || rsp_addr !== '0 ||
        rsp_line !== '0 || rsp_mask !== '0 || rsp_inv !== '0) begin
      failures++;
      $display("FAIL reset_vals got rdy=%b v=%b err=%b msg=%0d addr=%h mask=%b line=%h want all 0",
               req_ready, rsp_valid, err_pulse, rsp_msg, rsp_addr, rsp_mask, rsp_line);
    end
    count_init();
  endtask
  task automatic test_basic();
    do_req(REQ_V, line_addr_t'(5), '1, 4'b1111, 0);
  endtask
  task automatic test_write_read();
    line_t l = '0;
    l[63:32] = 32'hDEADBEEF;
    do_req(REQ_WT, line_addr_t'(3), l, 4'b0010, 0);
    do_req(REQ_S, line_addr_t'(3), '0, 4'b1111, 0);
    do_req(REQ_WT, line_addr_t'(3), '1, 4'b0000, 0);
    do_req(REQ_S, line_addr_t'(3), '0, 4'b0000, 0);
  endtask
  task automatic test_owner();
    line_t l = '0;
    l[31:0] = 32'h11;
    l[63:32] = 32'h22;
    do_req(REQ_O, line_addr_t'(7), '1, 4'b1111, 0);
    do_req(REQ_WB, line_addr_t'(7), l, 4'b0011, 0);
    checks++;
    if (dut.u_store.own_mem[7] !== 4'b1100) begin
      failures++;
      $display("FAIL owner_7 got=%b want=1100", dut.u_store.own_mem[7]);
    end
    do_req(REQ_ODATA, line_addr_t'(7), '0, 4'b0001, 0);
  endtask
  task automatic test_hold();
    do_req(REQ_V, line_addr_t'(7), '0, 4'b0101, 10);
  endtask
  task automatic test_error();
    do_req(mix_msg_t'(6), line_addr_t'(3), '1, 4'b1111, 0);
    do_req(mix_msg_t'(7), line_addr_t'(7), '1, 4'b1111, 0);
    do_req(REQ_S, line_addr_t'(3), '0, 4'b1111, 0);
  endtask
  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      line_addr_t a = line_addr_t'($urandom);
      line_t l;
      for (int w = 0; w < WORDS; w++) l[w*WORD_BITS +: WORD_BITS] = $urandom;
      a[5:0] = 6'($urandom_range(0, 7));
      do_req(mix_msg_t'($urandom_range(0, 7)), a, l, word_mask_t'($urandom), int'($urandom_range(0, 2)));
    end
  endtask
  task automatic test_back_to_back();
    int last = -1, accepts = 0, n = 0;
    rsp_ready = 1;
    req_valid = 1; req_msg = REQ_V; req_addr = line_addr_t'(9); req_mask = 4'b1111;
    for (int c = 0; c < 4 * (EXP_LAT + 1); c++) begin
      if (req_ready) begin
        if (last >= 0) begin
          checks++;
          if (c - last !== EXP_LAT + 1) begin
            failures++;
            $display("FAIL b2b_gap got=%0d want=%0d", c - last, EXP_LAT + 1);
          end
        end
        last = c;
        accepts++;
      end
      step();
    end
    req_valid = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    rsp_ready = 0;
    checks++;
    if (accepts !== 4 || !req_ready) begin
      failures++;
      $display("FAIL b2b_accepts got=%0d ready=%b want=4 ready=1", accepts, req_ready);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    req_valid = 1; req_msg = REQ_WT; req_addr = line_addr_t'(2); req_line = '1; req_mask = 4'b1111;
    step();
    req_valid = 0;
    step();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== (EXP_LAT == 2)) begin
      failures++;
      $display("FAIL mid_pre got ready=%b valid=%b want ready=0 valid=%b", req_ready, rsp_valid, EXP_LAT == 2);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got valid=%b ready=%b err=%b want 0 0 0", rsp_valid, req_ready, err_pulse);
    end
    count_init();
    do_req(REQ_S, line_addr_t'(2), '0, 4'b1111, 0);
    do_req(REQ_V, line_addr_t'(7), '0, 4'b1111, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_write_read();
    test_owner();
    test_hold();
    test_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
